// File: rtl/exttrig_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : exttrig_pkg
//  Description : Shared run-state encoding and default widths for the
//                external-trigger blocks and their register map.
//  Revision    : 1.0 - initial release
// ============================================================================
package exttrig_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } run_state_t;

    localparam int c_DEF_CNT_WIDTH   = 32;
    localparam int c_DEF_DEAD_WIDTH  = 16;
    localparam int c_DEF_PHASE_WIDTH = 8;

endpackage : exttrig_pkg
`default_nettype wire

// File: rtl/trig_run_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Interface   : trig_run_ctrl_if
//  Description : Control, candidate and readback signals of trig_run_ctrl.
//  Revision    : 1.0 - initial release
// ============================================================================
interface trig_run_ctrl_if
    import exttrig_pkg::*;
#(
    parameter int CNT_WIDTH   = c_DEF_CNT_WIDTH,
    parameter int DEAD_WIDTH  = c_DEF_DEAD_WIDTH,
    parameter int PHASE_WIDTH = c_DEF_PHASE_WIDTH
);
    logic                   startRun;
    logic                   stopRun;
    logic                   candidate;
    logic [PHASE_WIDTH-1:0] candPhase;
    logic                   busy;
    logic [DEAD_WIDTH-1:0]  deadTime;
    logic [CNT_WIDTH-1:0]   maxTrig;
    logic                   accept;
    logic [PHASE_WIDTH-1:0] acceptPhase;
    logic                   running;
    logic                   dead;
    logic                   runDone;
    logic [CNT_WIDTH-1:0]   trigCount;
    logic [CNT_WIDTH-1:0]   vetoBusyCount;
    logic [CNT_WIDTH-1:0]   vetoDeadCount;

    modport master (
        output startRun, stopRun, candidate, candPhase, busy, deadTime, maxTrig,
        input  accept, acceptPhase, running, dead, runDone,
               trigCount, vetoBusyCount, vetoDeadCount
    );

    modport slave (
        input  startRun, stopRun, candidate, candPhase, busy, deadTime, maxTrig,
        output accept, acceptPhase, running, dead, runDone,
               trigCount, vetoBusyCount, vetoDeadCount
    );

endinterface : trig_run_ctrl_if
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
//  Module      : sat_counter
//  Description : Up-counter with synchronous clear that sticks at all-ones.
//  Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  wire logic             clk40,
    input  wire logic             reset,
    input  wire logic             i_clr,
    input  wire logic             i_inc,
    output logic [WIDTH-1:0]      o_count
);
    localparam logic [WIDTH-1:0] c_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_count;

    // Clear wins over increment so a run start never carries a stale count.
    always_ff @(posedge clk40) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_inc && (r_count != '1)) begin
            r_count <= r_count + c_ONE;
        end
    end

    assign o_count = r_count;

endmodule : sat_counter
`default_nettype wire

// File: rtl/trig_run_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : trig_run_ctrl
//  Description : Run sequencing and trigger acceptance (busy veto, dead time,
//                trigger limit) with accept/veto counters, clk40 domain.
//  Revision    : 1.0 - initial release
// ============================================================================
module trig_run_ctrl
    import exttrig_pkg::*;
#(
    parameter int CNT_WIDTH   = c_DEF_CNT_WIDTH,
    parameter int DEAD_WIDTH  = c_DEF_DEAD_WIDTH,
    parameter int PHASE_WIDTH = c_DEF_PHASE_WIDTH
) (
    input  wire logic      clk40,
    input  wire logic      reset,
    trig_run_ctrl_if.slave bus
);
    localparam logic [CNT_WIDTH-1:0]  c_CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [DEAD_WIDTH-1:0] c_DEAD_ONE = {{(DEAD_WIDTH-1){1'b0}}, 1'b1};

    run_state_t             r_state;
    run_state_t             w_stateNext;
    logic [DEAD_WIDTH-1:0]  r_deadCnt;
    logic [DEAD_WIDTH-1:0]  w_deadCntNext;
    logic                   r_accept;
    logic [PHASE_WIDTH-1:0] r_acceptPhase;
    logic                   r_running;
    logic                   r_dead;
    logic                   r_runDone;

    logic                   w_accept;
    logic                   w_deadNow;
    logic                   w_limitNow;
    logic                   w_limitNext;
    logic                   w_clrCounts;
    logic                   w_runDoneNext;
    logic                   w_vetoBusy;
    logic                   w_vetoDead;
    logic [CNT_WIDTH-1:0]   w_trigCount;
    logic [CNT_WIDTH-1:0]   w_trigNext;
    logic [CNT_WIDTH-1:0]   w_vetoBusyCount;
    logic [CNT_WIDTH-1:0]   w_vetoDeadCount;

    assign w_deadNow  = (r_deadCnt != '0);
    assign w_limitNow = (bus.maxTrig != '0) && (w_trigCount >= bus.maxTrig);

    assign w_accept = (r_state == RUN) && bus.candidate && !bus.busy && !w_deadNow
                      && !bus.stopRun && !w_limitNow;

    // Count as it will read after this edge, so the limit-reaching accept
    // moves the run to STOP on the same edge.
    assign w_trigNext  = (w_accept && (w_trigCount != '1)) ? (w_trigCount + c_CNT_ONE)
                                                           : w_trigCount;
    assign w_limitNext = (bus.maxTrig != '0) && (w_trigNext >= bus.maxTrig);

    assign w_vetoBusy = (r_state == RUN) && bus.candidate && bus.busy;
    assign w_vetoDead = (r_state == RUN) && bus.candidate && !bus.busy && w_deadNow;

    always_comb begin
        w_deadCntNext = r_deadCnt;
        if (w_accept) begin
            w_deadCntNext = bus.deadTime;
        end else if (w_deadNow) begin
            w_deadCntNext = r_deadCnt - c_DEAD_ONE;
        end
    end

    always_comb begin
        w_stateNext   = r_state;
        w_clrCounts   = 1'b0;
        w_runDoneNext = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.startRun && !bus.stopRun) begin
                    w_stateNext = RUN;
                    w_clrCounts = 1'b1;
                end
            end
            RUN: begin
                if (bus.stopRun || w_limitNext) begin
                    w_stateNext = STOP;
                end
            end
            STOP: begin
                if (!w_deadNow) begin
                    w_stateNext   = IDLE;
                    w_runDoneNext = 1'b1;
                end
            end
            default: begin
                w_stateNext = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk40) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_ff @(posedge clk40) begin
        if (reset) begin
            r_deadCnt     <= '0;
            r_accept      <= 1'b0;
            r_acceptPhase <= '0;
            r_running     <= 1'b0;
            r_dead        <= 1'b0;
            r_runDone     <= 1'b0;
        end else begin
            r_deadCnt <= w_deadCntNext;
            r_accept  <= w_accept;
            if (w_accept) begin
                r_acceptPhase <= bus.candPhase;
            end
            r_running <= (w_stateNext == RUN);
            r_dead    <= (w_deadCntNext != '0);
            r_runDone <= w_runDoneNext;
        end
    end

    sat_counter #(.WIDTH(CNT_WIDTH)) u_trigCnt (
        .clk40   (clk40),
        .reset   (reset),
        .i_clr   (w_clrCounts),
        .i_inc   (w_accept),
        .o_count (w_trigCount)
    );

    sat_counter #(.WIDTH(CNT_WIDTH)) u_vetoBusyCnt (
        .clk40   (clk40),
        .reset   (reset),
        .i_clr   (w_clrCounts),
        .i_inc   (w_vetoBusy),
        .o_count (w_vetoBusyCount)
    );

    sat_counter #(.WIDTH(CNT_WIDTH)) u_vetoDeadCnt (
        .clk40   (clk40),
        .reset   (reset),
        .i_clr   (w_clrCounts),
        .i_inc   (w_vetoDead),
        .o_count (w_vetoDeadCount)
    );

    assign bus.accept        = r_accept;
    assign bus.acceptPhase   = r_acceptPhase;
    assign bus.running       = r_running;
    assign bus.dead          = r_dead;
    assign bus.runDone       = r_runDone;
    assign bus.trigCount     = w_trigCount;
    assign bus.vetoBusyCount = w_vetoBusyCount;
    assign bus.vetoDeadCount = w_vetoDeadCount;

endmodule : trig_run_ctrl
`default_nettype wire
